bcd_sub_sequencer: RTL

//  Digit-serial N-digit packed-BCD subtractor controller: computes A - B as
//  A + 9's(B) + 1, one digit per clock, LSD first. A negative difference is
//  re-complemented in a second N-cycle pass.

---
 rtl/bcd_pkg.sv | 23 ++
 rtl/bcd_nines_digit.sv | 11 +
 rtl/bcd_sub_sequencer.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/bcd_pkg.sv
// Shared types and the decimal-correcting digit adder for the BCD subtract sequencer.
package bcd_pkg;

    typedef logic [3:0] bcd_digit_t;

    localparam bcd_digit_t BCD_MAX = 4'd9;

    typedef enum logic [1:0] {IDLE, SUB, FIX, DONE} seq_state_t;

    // Returns {carry_out, digit}; any sum above 9 wraps by ten and carries.
    function automatic logic [4:0] bcd_add_dig(input bcd_digit_t x, input bcd_digit_t y,
                                               input logic cin);
        logic [4:0] s;
        logic [4:0] t;
        s = {1'b0, x} + {1'b0, y} + {4'b0000, cin};
        t = s - 5'd10;
        if (s > {1'b0, BCD_MAX})
            bcd_add_dig = {1'b1, t[3:0]};
        else
            bcd_add_dig = {1'b0, s[3:0]};
    endfunction

endpackage

// File: rtl/bcd_nines_digit.sv
// Combinational 9's complement of one BCD digit.
module bcd_nines_digit
    import bcd_pkg::*;
(
    input  logic [3:0] d,
    output logic [3:0] q
);

    assign q = BCD_MAX - d;

endmodule

// File: rtl/bcd_sub_sequencer.sv
// Digit-serial packed-BCD subtractor: A + 9's(B) + 1 LSD first, with a re-complement
// pass for negative results. Define BCD_SUB_DIGIT_CHECK_EN to reject non-BCD operands.
module bcd_sub_sequencer
    import bcd_pkg::*;
#(
    parameter int N_DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [4*N_DIGITS-1:0] a,
    input  logic [4*N_DIGITS-1:0] b,
    output logic                  busy,
    output logic                  done,
    output logic [4*N_DIGITS-1:0] result,
    output logic                  neg,
    output logic                  err
);

    localparam int W     = 4 * N_DIGITS;
    localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(N_DIGITS - 1);

    seq_state_t       state;
    logic [W-1:0]     a_q;
    logic [W-1:0]     b_q;
    logic [IDX_W-1:0] idx;
    logic             carry;
    logic             err_q;
    logic             bad_in;

    bcd_digit_t a_dig;
    bcd_digit_t b_dig;
    bcd_digit_t r_dig;
    bcd_digit_t nines_in;
    bcd_digit_t nines_out;
    bcd_digit_t addend;
    logic [4:0] sum;

    // One complementer and one adder serve both passes; FIX adds zero to 9's(result).
    always_comb begin
        a_dig    = a_q[{idx, 2'b00} +: 4];
        b_dig    = b_q[{idx, 2'b00} +: 4];
        r_dig    = result[{idx, 2'b00} +: 4];
        nines_in = (state == FIX) ? r_dig : b_dig;
        addend   = (state == FIX) ? 4'd0 : a_dig;
        sum      = bcd_add_dig(addend, nines_out, carry);
    end

    bcd_nines_digit u_nines (
        .d (nines_in),
        .q (nines_out)
    );

`ifdef BCD_SUB_DIGIT_CHECK_EN
    function automatic logic any_bad_digit(input logic [W-1:0] v);
        any_bad_digit = 1'b0;
        for (int i = 0; i < N_DIGITS; i++)
            if (v[i*4 +: 4] > BCD_MAX)
                any_bad_digit = 1'b1;
    endfunction

    assign bad_in = any_bad_digit(a) | any_bad_digit(b);
`else
    assign bad_in = 1'b0;
`endif

    assign err = err_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            neg    <= 1'b0;
            err_q  <= 1'b0;
            result <= '0;
            idx    <= '0;
            carry  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_q    <= a;
                        b_q    <= b;
                        idx    <= '0;
                        carry  <= 1'b1;
                        result <= '0;
                        neg    <= 1'b0;
                        busy   <= 1'b1;
                        if (bad_in) begin
                            err_q <= 1'b1;
                            state <= DONE;
                        end else begin
                            err_q <= 1'b0;
                            state <= SUB;
                        end
                    end
                end
                SUB: begin
                    result[{idx, 2'b00} +: 4] <= sum[3:0];
                    carry <= sum[4];
                    if (idx == LAST) begin
                        idx <= '0;
                        if (sum[4]) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            // No final carry means B > A: the digits hold the 10's complement.
                            state <= FIX;
                            carry <= 1'b1;
                        end
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                FIX: begin
                    result[{idx, 2'b00} +: 4] <= sum[3:0];
                    carry <= sum[4];
                    if (idx == LAST) begin
                        idx   <= '0;
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        neg   <= 1'b1;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    // Rejected operands arrive here without done set; pulse it one cycle later.
                    if (done) begin
                        done  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        done <= 1'b1;
                        busy <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
